// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: launch FSM state
// encodings and the default bit period used by the UART benches.
package uart_tx_fifo_pkg;

    // Default clocks per UART bit for the UART_RX/UART_TX benches.
    localparam int c_CLKS_PER_BIT = 16;

    // Launch controller states.
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the system-side producer / UART_TX and the
// transmit buffer. The slave side is the buffer itself.
interface uart_tx_fifo_if #(
    parameter int g_ADDR_W = 4
);
    logic              i_Wr_DV;
    logic [7:0]        i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [g_ADDR_W:0] o_Count;
    logic              o_Overflow;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic              i_TX_Active;
    logic              i_TX_Done;

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
    );

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered read data and registered
// occupancy/status flags. Writes while full are dropped; full is judged
// on the occupancy before any same-cycle pop.
module uart_sync_fifo #(
    parameter int g_DEPTH  = 16,
    parameter int g_ADDR_W = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [g_ADDR_W:0] count
);
    localparam logic [g_ADDR_W:0] c_FULL = (g_ADDR_W+1)'(g_DEPTH);

    logic [7:0]          mem_q [g_DEPTH];
    logic [g_ADDR_W-1:0] wr_ptr_q;
    logic [g_ADDR_W-1:0] rd_ptr_q;
    logic [g_ADDR_W:0]   count_q;
    logic [g_ADDR_W:0]   count_d;
    logic                full_q;
    logic                empty_q;
    logic [7:0]          rd_data_q;
    logic                wr_ok;
    logic                rd_ok;

    assign wr_ok = wr_en && !full_q;
    assign rd_ok = rd_en && !empty_q;

    // Next occupancy: a simultaneous accepted write and pop cancel out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Byte storage; contents are only meaningful between the pointers.
    always_ff @(posedge i_Clk) begin
        // NOTE: the storage array is deliberately not reset; the cleared pointers make old contents unreachable.
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy, status flags and read-data register.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_Rst_L) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            full_q  <= (count_d == c_FULL);
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch controller in front of UART_TX. Bytes queue in
// a FIFO; one is popped and launched with a single-cycle o_TX_DV pulse
// only when UART_TX is neither active nor signalling done, and the next
// launch waits for that frame's done.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int g_DEPTH  = 16,
    parameter int g_ADDR_W = 4
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    uart_tx_fifo_if.slave bus
);
    tx_state_e   state_q;
    tx_state_e   state_d;
    logic        pop;
    logic        tx_dv_q;
    logic        tx_dv_d;
    logic        overflow_q;
    logic        overflow_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic [g_ADDR_W:0] fifo_count;

    uart_sync_fifo #(
        .g_DEPTH  (g_DEPTH),
        .g_ADDR_W (g_ADDR_W)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .wr_en   (bus.i_Wr_DV),
        .wr_data (bus.i_Wr_Byte),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Launch FSM next state; the done term in the guard stops a second
    // launch while UART_TX is still finishing the previous frame.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (bus.i_Wr_DV & fifo_full);
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !bus.i_TX_Active && !bus.i_TX_Done) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH:    state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.i_TX_Done) begin
                    state_d = S_IDLE;
                end
            end
            default:     state_d = S_IDLE;
        endcase
        tx_dv_d = pop;
    end

    // State, launch pulse and sticky overflow registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= S_IDLE;
            tx_dv_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_dv_q    <= tx_dv_d;
            overflow_q <= overflow_d;
        end
    end

    // The FIFO read register loads on the pop edge, so it doubles as the
    // held launch byte.
    assign bus.o_TX_Byte  = fifo_rd_data;
    assign bus.o_TX_DV    = tx_dv_q;
    assign bus.o_Overflow = overflow_q;
    assign bus.o_Full     = fifo_full;
    assign bus.o_Empty    = fifo_empty;
    assign bus.o_Count    = fifo_count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: emulates UART_TX active/done behaviour and
// checks every cycle against a queue-based model of the buffer.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.g_ADDR_W(AW)) bus ();

    uart_tx_fifo #(.g_DEPTH(DEPTH), .g_ADDR_W(AW)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_dv;
    bit         m_out;
    logic [7:0] m_byte;

    // UART_TX emulation state and received bytes.
    int         busy_cnt = 0;
    int         done_cnt = 0;
    bit         force_busy = 1'b0;
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the UART_TX emulation, drive inputs, step the
    // model, cross the rising edge, then compare on the falling edge.
    task automatic tick(input bit rst, input bit wr, input logic [7:0] data, input bit wr_on_pop);
        bit launch;
        bit w;
        int occ;
        if (bus.o_TX_DV === 1'b1) begin
            check("dv_while_tx_busy", {31'd0, bus.i_TX_Active | bus.i_TX_Done}, 0);
            rx_q.push_back(bus.o_TX_Byte);
            busy_cnt = $urandom_range(c_CLKS_PER_BIT, 4);
            done_cnt = 0;
        end else if (busy_cnt > 0) begin
            if (!force_busy) busy_cnt--;
            if (busy_cnt == 0) done_cnt = $urandom_range(3, 1);
        end else if (done_cnt > 0) begin
            done_cnt--;
        end
        bus.i_TX_Active = (busy_cnt > 0);
        bus.i_TX_Done   = (busy_cnt == 0) && (done_cnt > 0);

        launch = rst && !m_out && (m_q.size() > 0) && !bus.i_TX_Active && !bus.i_TX_Done;
        w = wr_on_pop ? launch : wr;
        rst_l         = rst;
        bus.i_Wr_DV   = w;
        bus.i_Wr_Byte = data;

        if (!rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_dv   = 1'b0;
            m_out  = 1'b0;
            m_byte = 8'h00;
        end else begin
            occ = m_q.size();
            if (launch) begin
                m_byte = m_q.pop_front();
                m_out  = 1'b1;
            end else if (bus.i_TX_Done) begin
                m_out = 1'b0;
            end
            if (w) begin
                if (occ == DEPTH) m_ovf = 1'b1;
                else              m_q.push_back(data);
            end
            m_dv = launch;
        end

        @(posedge clk);
        @(negedge clk);
        check("tx_dv",    {31'd0, bus.o_TX_DV}, {31'd0, m_dv});
        check("tx_byte",  {24'd0, bus.o_TX_Byte}, {24'd0, m_byte});
        check("count",    {27'd0, bus.o_Count}, m_q.size());
        check("full",     {31'd0, bus.o_Full}, {31'd0, m_q.size() == DEPTH});
        check("empty",    {31'd0, bus.o_Empty}, {31'd0, m_q.size() == 0});
        check("overflow", {31'd0, bus.o_Overflow}, {31'd0, m_ovf});
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((m_q.size() > 0 || m_out || bus.i_TX_Active || bus.i_TX_Done) && n < max) begin
            tick(1'b1, 1'b0, 8'h00, 1'b0);
            n++;
        end
        check("drain_timeout", {31'd0, n < max}, 1);
    endtask

    task automatic hold_busy();
        force_busy = 1'b1;
        if (busy_cnt == 0) busy_cnt = 1;
        done_cnt = 0;
    endtask

    initial begin
        int base;
        int peak;
        int n;
        logic [7:0] burst [4];
        burst = '{8'hA5, 8'h5A, 8'h00, 8'hFF};

        bus.i_Wr_DV     = 1'b0;
        bus.i_Wr_Byte   = 8'h00;
        bus.i_TX_Active = 1'b0;
        bus.i_TX_Done   = 1'b0;
        @(negedge clk);

        // Reset.
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_empty", {31'd0, bus.o_Empty}, 1);
        check("rst_count", {27'd0, bus.o_Count}, 0);

        // Single byte: launch two edges after the write.
        base = rx_q.size();
        tick(1'b1, 1'b1, 8'h37, 1'b0);
        check("single_not_empty", {31'd0, bus.o_Empty}, 0);
        check("single_no_dv_yet", {31'd0, bus.o_TX_DV}, 0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        check("single_dv", {31'd0, bus.o_TX_DV}, 1);
        check("single_byte", {24'd0, bus.o_TX_Byte}, 32'h37);
        check("single_count0", {27'd0, bus.o_Count}, 0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        check("single_dv_one_cycle", {31'd0, bus.o_TX_DV}, 0);
        drain(500);
        check("single_rx_n", rx_q.size() - base, 1);
        check("single_rx", {24'd0, rx_q[base]}, 32'h37);

        // Burst of four on consecutive cycles.
        base = rx_q.size();
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, burst[i], 1'b0);
            if (int'(bus.o_Count) > peak) peak = int'(bus.o_Count);
        end
        drain(1000);
        check("burst_peak", {31'd0, peak == 3 || peak == 4}, 1);
        check("burst_rx_n", rx_q.size() - base, 4);
        for (int i = 0; i < 4; i++) check("burst_rx", {24'd0, rx_q[base+i]}, {24'd0, burst[i]});

        // Fill with TX held busy, overflow on the 17th write.
        base = rx_q.size();
        hold_busy();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b1, 8'(i + 8'h40), 1'b0);
        check("full_flag", {31'd0, bus.o_Full}, 1);
        check("full_count", {27'd0, bus.o_Count}, DEPTH);
        check("no_ovf_at_16", {31'd0, bus.o_Overflow}, 0);
        tick(1'b1, 1'b1, 8'hEE, 1'b0);
        check("ovf_17th", {31'd0, bus.o_Overflow}, 1);
        check("ovf_count", {27'd0, bus.o_Count}, DEPTH);

        // Write on the pop cycle while full: dropped, count 15.
        force_busy = 1'b0;
        n = 0;
        do begin
            tick(1'b1, 1'b0, 8'hDD, 1'b1);
            n++;
        end while (!m_dv && n < 100);
        check("full_pop_wait", {31'd0, n < 100}, 1);
        check("full_pop_wr_count", {27'd0, bus.o_Count}, DEPTH - 1);
        drain(2000);
        check("full_rx_n", rx_q.size() - base, DEPTH);
        for (int i = 0; i < DEPTH; i++) check("full_rx", {24'd0, rx_q[base+i]}, 32'(i + 8'h40));

        // Write on the pop cycle at count 5: count stays 5.
        hold_busy();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 8'(i + 8'h60), 1'b0);
        force_busy = 1'b0;
        n = 0;
        do begin
            tick(1'b1, 1'b0, 8'h65, 1'b1);
            n++;
        end while (!m_dv && n < 100);
        check("c5_pop_wait", {31'd0, n < 100}, 1);
        check("c5_pop_wr_count", {27'd0, bus.o_Count}, 5);
        drain(2000);

        // Wrap-around: 40 sequential bytes in bursts of ten.
        base = rx_q.size();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 10; j++) tick(1'b1, 1'b1, 8'(b * 10 + j), 1'b0);
            drain(2000);
        end
        check("wrap_rx_n", rx_q.size() - base, 40);
        for (int i = 0; i < 40; i++) check("wrap_rx", {24'd0, rx_q[base+i]}, i);

        // Random traffic.
        for (int i = 0; i < 400; i++) tick(1'b1, ($urandom_range(2, 0) == 0), 8'($urandom), 1'b0);
        drain(4000);

        // Reset mid-frame with six bytes queued.
        tick(1'b1, 1'b1, 8'h11, 1'b0);
        n = 0;
        do begin
            tick(1'b1, 1'b0, 8'h00, 1'b0);
            n++;
        end while (!m_dv && n < 100);
        check("mid_launch_wait", {31'd0, n < 100}, 1);
        tick(1'b1, 1'b1, 8'hC0, 1'b0);
        hold_busy();
        for (int i = 1; i < 6; i++) tick(1'b1, 1'b1, 8'(i + 8'hC0), 1'b0);
        check("mid_count6", {27'd0, bus.o_Count}, 6);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("mid_rst_count", {27'd0, bus.o_Count}, 0);
        check("mid_rst_empty", {31'd0, bus.o_Empty}, 1);
        check("mid_rst_dv", {31'd0, bus.o_TX_DV}, 0);
        check("mid_rst_byte", {24'd0, bus.o_TX_Byte}, 0);
        base = rx_q.size();
        force_busy = 1'b0;
        for (int i = 0; i < 80; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
        check("mid_no_tx_after_rst", rx_q.size(), base);
        tick(1'b1, 1'b1, 8'h99, 1'b0);
        drain(500);
        check("post_rst_rx_n", rx_q.size() - base, 1);
        check("post_rst_rx", {24'd0, rx_q[rx_q.size()-1]}, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch controller that sits directly upstream of UART_TX. It accepts bursts of bytes from the system side and stores them in a synchronous FIFO. It pops one byte at a time and drives UART_TX's i_TX_DV/i_TX_Byte handshake, waiting for each frame to complete before launching the next. This lets producers write back-to-back without polling o_TX_Active.

Parameters:
g_DEPTH, 16, FIFO depth in bytes; power of two, minimum 2
g_ADDR_W, 4, log2(g_DEPTH); pointer width

Ports:
i_Clk  input  1  system clock; all logic on rising edge
i_Rst_L  input  1  synchronous active-low reset
i_Wr_DV  input  1  write strobe; one byte accepted per cycle when high
i_Wr_Byte  input  8  byte to enqueue, sampled with i_Wr_DV
o_Full  output  1  FIFO holds g_DEPTH bytes
o_Empty  output  1  FIFO holds 0 bytes
o_Count  output  g_ADDR_W+1  current occupancy
o_Overflow  output  1  sticky; set when a write is attempted while full
o_TX_DV  output  1  one-cycle launch pulse to UART_TX i_TX_DV
o_TX_Byte  output  8  byte to UART_TX i_TX_Byte; held stable until next launch
i_TX_Active  input  1  from UART_TX o_TX_Active
i_TX_Done  input  1  from UART_TX o_TX_Done

Behaviour:
- Reset (i_Rst_L=0 at a rising edge):
  - Pointers and count cleared; o_Empty=1, o_Full=0, o_Count=0.
  - o_Overflow=0, o_TX_DV=0, o_TX_Byte=8'h00.
  - FSM goes to S_IDLE.
- Reset mid-frame:
  - FIFO contents are discarded.
  - The in-flight UART_TX frame is not aborted by this block.
  - After reset the FSM re-enters S_IDLE and obeys the launch guard below, so no byte launches until UART_TX is idle.
- All outputs are registered.
- Write side:
  - i_Wr_DV=1 and not full: byte stored at wr_ptr, wr_ptr increments modulo g_DEPTH.
  - i_Wr_DV=1 and full: byte dropped, o_Overflow set to 1; it clears only on reset.
- Pop occurs only in the S_IDLE->S_LAUNCH transition: rd_ptr increments modulo g_DEPTH.
- Simultaneous write and pop in the same cycle:
  - Both take effect; count is unchanged.
  - When full, a write coinciding with a pop is still dropped, because full is evaluated before the pop.
- Count and flags update on the same edge as the pointer change.
- FSM states:
  - S_IDLE: if !o_Empty && !i_TX_Active && !i_TX_Done, then pop, load o_TX_Byte, set o_TX_DV=1, go to S_LAUNCH. Otherwise stay.
  - S_LAUNCH (1 cycle): o_TX_DV returns to 0; go to S_WAIT_DONE.
  - S_WAIT_DONE: stay until i_TX_Done=1, then go to S_IDLE.
- Latency:
  - Write at edge N into an empty FIFO with UART_TX idle: o_Empty=0 after edge N.
  - o_TX_DV=1 after edge N+1; o_Count returns to 0 after edge N+1.
- Launch guard: the !i_TX_Done term prevents double-launch while UART_TX holds Done high during its cleanup/idle transition.
- Ordering is strictly FIFO.
- At most one launch per UART frame; o_TX_DV is never high on two consecutive cycles.
- Pointer wrap-around: g_ADDR_W-bit pointers wrap naturally; occupancy is tracked by a separate (g_ADDR_W+1)-bit counter.

Decomposition:
- Shared include (uart_defs.vh): FSM state encodings S_IDLE=2'd0, S_LAUNCH=2'd1, S_WAIT_DONE=2'd2. The same file holds the default c_CLKS_PER_BIT used by UART_RX/UART_TX benches.
- One sub-module, uart_sync_fifo:
  - Parameterised by g_DEPTH and g_ADDR_W.
  - Ports: i_Clk, i_Rst_L, wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - rd_data is registered on rd_en.
- Top level holds the FSM, the overflow flag and the output registers.

Test Plan:
- Setup for all scenarios: UART_TX and UART_RX with g_CLKS_PER_BIT=16, serial line looped back.
- Single byte: write 8'h37 into an idle system -> o_TX_DV pulses exactly once, 2 cycles after the write; UART_RX reports 8'h37.
- Burst of 4: write 8'hA5, 8'h5A, 8'h00, 8'hFF on consecutive cycles -> o_Count peaks at 3 or 4; RX receives the same four bytes in order; o_TX_DV count = 4; no launch while i_TX_Active=1.
- Full/overflow: with TX held busy, write 17 bytes (g_DEPTH=16) -> o_Full=1 after 16 writes; the 17th write is dropped and o_Overflow=1; RX receives only the first 16 bytes in order.
- Simultaneous read/write: at full, issue a write on the exact pop cycle -> write dropped, count 15. At count 5, write on the pop cycle -> count stays 5.
- Wrap-around: send 40 sequential bytes 8'h00..8'h27 in bursts of 10 -> all received in order; pointers wrap twice without error.
- Reset mid-operation: drop i_Rst_L for 1 cycle while 6 bytes are queued and a frame is in flight:
  - Outputs reach reset values on the next edge.
  - No o_TX_DV until i_TX_Active=0 and i_TX_Done=0.
  - No queued byte is transmitted after reset.
